// File: rtl/arm_handshake_memory_if.sv
// rtl/arm_handshake_memory_if.sv - MFA/MFC request/complete bus between the CPU and its memory slave
interface arm_handshake_memory_if #(
    parameter int ADDR_W = 8
);
    logic              MFA;
    logic              READ_WRITE;
    logic              WORD_BYTE;
    logic [ADDR_W-1:0] MEMADD;
    logic [31:0]       WDATA;
    logic [31:0]       MEMDAT;
    logic              MEMLOAD;
    logic              MFC;
    logic              ERR;

    modport master (
        output MFA, READ_WRITE, WORD_BYTE, MEMADD, WDATA,
        input  MEMDAT, MEMLOAD, MFC, ERR
    );

    modport slave (
        input  MFA, READ_WRITE, WORD_BYTE, MEMADD, WDATA,
        output MEMDAT, MEMLOAD, MFC, ERR
    );
endinterface

// File: rtl/arm_handshake_memory.sv
// rtl/arm_handshake_memory.sv - parametrised 4-phase MFA/MFC memory slave with wait states and preload port
module arm_handshake_memory #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int BYTE_ADDR   = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    arm_handshake_memory_if.slave bus,
    input  logic                  PL_EN,
    input  logic [ADDR_W-1:0]     PL_ADDR,
    input  logic [31:0]           PL_DATA
);
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]        WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d, wb_q, wb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       memdat_q, memdat_d;
    logic              memload_q, memload_d, mfc_q, mfc_d, err_q, err_d;

    logic [31:0]       mem [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_wa;
    logic [31:0]       mem_wd;

    // With zero wait states the commit happens on the capture edge, so the
    // access is decoded from the live bus instead of the captured copy.
    logic              live;
    logic [ADDR_W-1:0] c_addr;
    logic              c_rw, c_wb, commit, in_range;
    logic [31:0]       c_wdata, rd_word, merged;
    logic [ADDR_W:0]   c_idx;
    logic [1:0]        c_lane;
    logic [7:0]        lane_byte;

    assign live     = (state_q == S_IDLE);
    assign c_addr   = live ? bus.MEMADD     : addr_q;
    assign c_rw     = live ? bus.READ_WRITE : rw_q;
    assign c_wb     = live ? bus.WORD_BYTE  : wb_q;
    assign c_wdata  = live ? bus.WDATA      : wdata_q;
    assign c_idx    = (BYTE_ADDR != 0) ? {3'b000, c_addr[ADDR_W-1:2]} : {1'b0, c_addr};
    assign c_lane   = (BYTE_ADDR != 0) ? c_addr[1:0] : 2'b00;
    assign in_range = (c_idx < DEPTH_L);
    assign rd_word  = mem[c_idx[IDX_W-1:0]];

    always_comb begin
        merged    = rd_word;
        lane_byte = rd_word[{c_lane, 3'b000} +: 8];
        merged[{c_lane, 3'b000} +: 8] = c_wdata[7:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wb_d      = wb_q;
        wdata_d   = wdata_q;
        memdat_d  = memdat_q;
        memload_d = memload_q;
        mfc_d     = mfc_q;
        err_d     = err_q;
        commit    = 1'b0;
        mem_we    = 1'b0;
        mem_wa    = PL_ADDR[IDX_W-1:0];
        mem_wd    = PL_DATA;

        case (state_q)
            S_IDLE: begin
                if (bus.MFA) begin
                    addr_d  = bus.MEMADD;
                    rw_d    = bus.READ_WRITE;
                    wb_d    = bus.WORD_BYTE;
                    wdata_d = bus.WDATA;
                    cnt_d   = WAIT_L;
                    if (WAIT_L == 4'd0) begin
                        commit  = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (PL_EN && ({1'b0, PL_ADDR} < DEPTH_L)) begin
                    mem_we = 1'b1;
                end
            end
            S_WAIT: begin
                if (!bus.MFA) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                if (!bus.MFA) begin
                    mfc_d     = 1'b0;
                    memload_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            mfc_d = 1'b1;
            err_d = !in_range;
            if (c_rw) begin
                memload_d = 1'b1;
                if (!in_range)  memdat_d = 32'h0;
                else if (c_wb)  memdat_d = rd_word;
                else            memdat_d = {24'h0, lane_byte};
            end else if (in_range) begin
                mem_we = 1'b1;
                mem_wa = c_idx[IDX_W-1:0];
                mem_wd = c_wb ? c_wdata : merged;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wb_q      <= 1'b0;
            wdata_q   <= 32'h0;
            memdat_q  <= 32'h0;
            memload_q <= 1'b0;
            mfc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wb_q      <= wb_d;
            wdata_q   <= wdata_d;
            memdat_q  <= memdat_d;
            memload_q <= memload_d;
            mfc_q     <= mfc_d;
            err_q     <= err_d;
        end
    end

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge Clk) begin
        if (Reset && mem_we) mem[mem_wa] <= mem_wd;
    end

    assign bus.MEMDAT  = memdat_q;
    assign bus.MEMLOAD = memload_q;
    assign bus.MFC     = mfc_q;
    assign bus.ERR     = err_q;
endmodule

// File: tb/tb_arm_handshake_memory.sv
// tb/tb_arm_handshake_memory.sv - directed self-checking bench for arm_handshake_memory
module tb_arm_handshake_memory;
    logic       clk;
    logic       Reset;
    logic       pl_en0, pl_en1;
    logic [7:0] pl_addr0, pl_addr1;
    logic [31:0] pl_data0, pl_data1;
    int n_checks = 0;
    int n_fail   = 0;

    arm_handshake_memory_if #(.ADDR_W(8)) if0 ();
    arm_handshake_memory_if #(.ADDR_W(8)) if1 ();

    arm_handshake_memory #(.ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(2), .BYTE_ADDR(1)) u_dut0 (
        .Clk(clk), .Reset(Reset), .bus(if0.slave),
        .PL_EN(pl_en0), .PL_ADDR(pl_addr0), .PL_DATA(pl_data0)
    );

    arm_handshake_memory #(.ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(0), .BYTE_ADDR(0)) u_dut1 (
        .Clk(clk), .Reset(Reset), .bus(if1.slave),
        .PL_EN(pl_en1), .PL_ADDR(pl_addr1), .PL_DATA(pl_data1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pl0(input logic [7:0] a, input logic [31:0] d);
        pl_en0 = 1'b1; pl_addr0 = a; pl_data0 = d;
        tick();
        pl_en0 = 1'b0;
    endtask

    task automatic pl1(input logic [7:0] a, input logic [31:0] d);
        pl_en1 = 1'b1; pl_addr1 = a; pl_data1 = d;
        tick();
        pl_en1 = 1'b0;
    endtask

    // Raise MFA on DUT0 and return the number of edges after the capture edge until MFC.
    task automatic start0(input logic rw, input logic wb, input logic [7:0] a,
                          input logic [31:0] wd, output int lat);
        if0.READ_WRITE = rw; if0.WORD_BYTE = wb; if0.MEMADD = a; if0.WDATA = wd;
        if0.MFA = 1'b1;
        lat = -1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (if0.MFC === 1'b1) begin lat = n; break; end
        end
        if (lat < 0) begin $display("FAIL mfc_timeout0: no MFC within 20 edges"); n_fail++; end
        n_checks++;
    endtask

    task automatic end0();
        if0.MFA = 1'b0;
        tick();
    endtask

    task automatic start1(input logic rw, input logic wb, input logic [7:0] a, input logic [31:0] wd);
        if1.READ_WRITE = rw; if1.WORD_BYTE = wb; if1.MEMADD = a; if1.WDATA = wd;
        if1.MFA = 1'b1;
        tick();
    endtask

    task automatic end1();
        if1.MFA = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_checks++; if (if0.MFC !== 1'b0) begin $display("FAIL rst_mfc: got %b exp 0", if0.MFC); n_fail++; end
        n_checks++; if (if0.MEMLOAD !== 1'b0) begin $display("FAIL rst_memload: got %b exp 0", if0.MEMLOAD); n_fail++; end
        n_checks++; if (if0.ERR !== 1'b0) begin $display("FAIL rst_err: got %b exp 0", if0.ERR); n_fail++; end
        n_checks++; if (if0.MEMDAT !== 32'h0) begin $display("FAIL rst_memdat: got %h exp 0", if0.MEMDAT); n_fail++; end
        n_checks++; if (if1.MFC !== 1'b0) begin $display("FAIL rst_mfc1: got %b exp 0", if1.MFC); n_fail++; end
    endtask

    task automatic test_read();
        int lat;
        pl0(8'd0, 32'hE2010000);
        start0(1'b1, 1'b1, 8'd0, 32'h0, lat);
        n_checks++; if (lat !== 2) begin $display("FAIL rd_latency: got %0d exp 2", lat); n_fail++; end
        n_checks++; if (if0.MEMDAT !== 32'hE2010000) begin $display("FAIL rd_data: got %h exp e2010000", if0.MEMDAT); n_fail++; end
        n_checks++; if (if0.MEMLOAD !== 1'b1) begin $display("FAIL rd_memload: got %b exp 1", if0.MEMLOAD); n_fail++; end
        tick();
        n_checks++; if (if0.MFC !== 1'b1) begin $display("FAIL rd_hold_mfc: got %b exp 1", if0.MFC); n_fail++; end
        end0();
        n_checks++; if (if0.MFC !== 1'b0) begin $display("FAIL rd_mfc_fall: got %b exp 0", if0.MFC); n_fail++; end
        n_checks++; if (if0.MEMLOAD !== 1'b0) begin $display("FAIL rd_memload_fall: got %b exp 0", if0.MEMLOAD); n_fail++; end
        n_checks++; if (if0.MEMDAT !== 32'hE2010000) begin $display("FAIL rd_memdat_hold: got %h exp e2010000", if0.MEMDAT); n_fail++; end
    endtask

    task automatic test_byte_access();
        int lat;
        start0(1'b0, 1'b1, 8'd8, 32'hDEADBEEF, lat);
        n_checks++; if (if0.MEMLOAD !== 1'b0) begin $display("FAIL wr_memload: got %b exp 0", if0.MEMLOAD); n_fail++; end
        n_checks++; if (if0.ERR !== 1'b0) begin $display("FAIL wr_err: got %b exp 0", if0.ERR); n_fail++; end
        end0();
        start0(1'b1, 1'b0, 8'd9, 32'h0, lat);
        n_checks++; if (if0.MEMDAT !== 32'h000000BE) begin $display("FAIL byte_rd: got %h exp 000000be", if0.MEMDAT); n_fail++; end
        end0();
        start0(1'b0, 1'b0, 8'd10, 32'hAAAAAA55, lat);
        end0();
        start0(1'b1, 1'b1, 8'd8, 32'h0, lat);
        n_checks++; if (if0.MEMDAT !== 32'hDE55BEEF) begin $display("FAIL byte_wr: got %h exp de55beef", if0.MEMDAT); n_fail++; end
        end0();
        start0(1'b1, 1'b1, 8'd11, 32'h0, lat);
        n_checks++; if (if0.MEMDAT !== 32'hDE55BEEF) begin $display("FAIL unaligned_rd: got %h exp de55beef", if0.MEMDAT); n_fail++; end
        end0();
    endtask

    task automatic test_abort();
        int lat;
        pl0(8'd16, 32'h11111111);
        if0.READ_WRITE = 1'b0; if0.WORD_BYTE = 1'b1; if0.MEMADD = 8'h40; if0.WDATA = 32'hCAFEF00D;
        if0.MFA = 1'b1;
        tick();
        tick();
        if0.MFA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (if0.MFC !== 1'b0) begin $display("FAIL abort_mfc: got %b exp 0 at %0d", if0.MFC, i); n_fail++; end
        end
        start0(1'b1, 1'b1, 8'h40, 32'h0, lat);
        n_checks++; if (if0.MEMDAT !== 32'h11111111) begin $display("FAIL abort_nowrite: got %h exp 11111111", if0.MEMDAT); n_fail++; end
        n_checks++; if (lat !== 2) begin $display("FAIL abort_next_lat: got %0d exp 2", lat); n_fail++; end
        end0();
    endtask

    task automatic test_reset_in_ack();
        int lat;
        pl0(8'd4, 32'hA5A5A5A5);
        pl0(8'd5, 32'h5A5A5A5A);
        start0(1'b1, 1'b1, 8'd16, 32'h0, lat);
        n_checks++; if (if0.MEMDAT !== 32'hA5A5A5A5) begin $display("FAIL rack_pre: got %h exp a5a5a5a5", if0.MEMDAT); n_fail++; end
        Reset = 1'b0;
        #1;
        n_checks++; if (if0.MFC !== 1'b0) begin $display("FAIL rack_mfc: got %b exp 0", if0.MFC); n_fail++; end
        n_checks++; if (if0.MEMLOAD !== 1'b0) begin $display("FAIL rack_memload: got %b exp 0", if0.MEMLOAD); n_fail++; end
        n_checks++; if (if0.MEMDAT !== 32'h0) begin $display("FAIL rack_memdat: got %h exp 0", if0.MEMDAT); n_fail++; end
        if0.MFA = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        start0(1'b1, 1'b1, 8'd16, 32'h0, lat);
        n_checks++; if (if0.MEMDAT !== 32'hA5A5A5A5) begin $display("FAIL rack_keep4: got %h exp a5a5a5a5", if0.MEMDAT); n_fail++; end
        end0();
        start0(1'b1, 1'b1, 8'd20, 32'h0, lat);
        n_checks++; if (if0.MEMDAT !== 32'h5A5A5A5A) begin $display("FAIL rack_keep5: got %h exp 5a5a5a5a", if0.MEMDAT); n_fail++; end
        end0();
        start0(1'b1, 1'b1, 8'd0, 32'h0, lat);
        n_checks++; if (if0.MEMDAT !== 32'hE2010000) begin $display("FAIL rack_keep0: got %h exp e2010000", if0.MEMDAT); n_fail++; end
        end0();
    endtask

    task automatic test_out_of_range();
        pl1(8'd60, 32'h0BADC0DE);
        start1(1'b1, 1'b1, 8'hFC, 32'h0);
        n_checks++; if (if1.ERR !== 1'b1) begin $display("FAIL oor_rd_err: got %b exp 1", if1.ERR); n_fail++; end
        n_checks++; if (if1.MFC !== 1'b1) begin $display("FAIL oor_rd_mfc: got %b exp 1", if1.MFC); n_fail++; end
        n_checks++; if (if1.MEMDAT !== 32'h0) begin $display("FAIL oor_rd_data: got %h exp 0", if1.MEMDAT); n_fail++; end
        end1();
        n_checks++; if (if1.ERR !== 1'b0) begin $display("FAIL oor_err_fall: got %b exp 0", if1.ERR); n_fail++; end
        start1(1'b0, 1'b1, 8'hFC, 32'h12345678);
        n_checks++; if (if1.ERR !== 1'b1) begin $display("FAIL oor_wr_err: got %b exp 1", if1.ERR); n_fail++; end
        end1();
        start1(1'b1, 1'b1, 8'd60, 32'h0);
        n_checks++; if (if1.MEMDAT !== 32'h0BADC0DE) begin $display("FAIL oor_nochange: got %h exp 0badc0de", if1.MEMDAT); n_fail++; end
        n_checks++; if (if1.ERR !== 1'b0) begin $display("FAIL inr_err: got %b exp 0", if1.ERR); n_fail++; end
        end1();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        for (int i = 0; i < 12; i++) pl1(8'(i), 32'h10000000 + 32'(i * 3));
        for (int i = 0; i < 12; i++) begin
            exp_d = 32'h10000000 + 32'(i * 3);
            start1(1'b1, 1'b1, 8'(i), 32'h0);
            n_checks++; if (if1.MFC !== 1'b1) begin $display("FAIL b2b_mfc[%0d]: got %b exp 1", i, if1.MFC); n_fail++; end
            n_checks++; if (if1.MEMDAT !== exp_d) begin $display("FAIL b2b_data[%0d]: got %h exp %h", i, if1.MEMDAT, exp_d); n_fail++; end
            pl_en1 = 1'b1; pl_addr1 = 8'(i); pl_data1 = 32'hFFFFFFFF;
            tick();
            pl_en1 = 1'b0;
            n_checks++; if (if1.MFC !== 1'b1) begin $display("FAIL b2b_hold[%0d]: got %b exp 1", i, if1.MFC); n_fail++; end
            end1();
            n_checks++; if (if1.MFC !== 1'b0) begin $display("FAIL b2b_fall[%0d]: got %b exp 0", i, if1.MFC); n_fail++; end
        end
        for (int i = 0; i < 12; i += 4) begin
            exp_d = 32'h10000000 + 32'(i * 3);
            start1(1'b1, 1'b1, 8'(i), 32'h0);
            n_checks++; if (if1.MEMDAT !== exp_d) begin $display("FAIL b2b_pl_ignored[%0d]: got %h exp %h", i, if1.MEMDAT, exp_d); n_fail++; end
            end1();
        end
        start1(1'b0, 1'b1, 8'd30, 32'h01020304);
        if1.WDATA = 32'h99999999;
        tick();
        tick();
        end1();
        start1(1'b1, 1'b1, 8'd30, 32'h0);
        n_checks++; if (if1.MEMDAT !== 32'h01020304) begin $display("FAIL held_mfa_single: got %h exp 01020304", if1.MEMDAT); n_fail++; end
        end1();
    endtask

    initial begin
        Reset = 1'b0;
        pl_en0 = 1'b0; pl_addr0 = '0; pl_data0 = '0;
        pl_en1 = 1'b0; pl_addr1 = '0; pl_data1 = '0;
        if0.MFA = 1'b0; if0.READ_WRITE = 1'b0; if0.WORD_BYTE = 1'b0; if0.MEMADD = '0; if0.WDATA = '0;
        if1.MFA = 1'b0; if1.READ_WRITE = 1'b0; if1.WORD_BYTE = 1'b0; if1.MEMADD = '0; if1.WDATA = '0;
        tick();
        tick();
        test_reset();
        Reset = 1'b1;
        tick();
        test_read();
        test_byte_access();
        test_abort();
        test_reset_in_ack();
        test_out_of_range();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
